// File: rtl/stego_decode.sv
// Purpose  : recovers one hidden bit per 8x8 DCT block (coefficient at EMBED_IDX, quantized by 1/18,
//            LSB descrambled with a three-LFSR keystream) and packs the bits LSB-first into bytes.
// Latency  : msg_bit_valid rises 2 cycles after the clock edge that samples the embed-index coefficient.
// Backpress: none; strobes are single-cycle and the consumer must take them.
// Ports    : clk/rst (async active-high); coef_in/coef_valid/blk_sync in; msg_bit/msg_bit_valid,
//            msg_byte/msg_byte_valid, byte_cnt out.
module stego_decode #(
  parameter int          EMBED_IDX = 43,
  parameter int          Q_RECIP   = 228,
  parameter logic [18:0] SEED_1    = 19'd1876,
  parameter logic [21:0] SEED_2    = 22'd20007,
  parameter logic [22:0] SEED_3    = 23'd14376
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] coef_in,
  input  logic        coef_valid,
  input  logic        blk_sync,
  output logic        msg_bit,
  output logic        msg_bit_valid,
  output logic [7:0]  msg_byte,
  output logic        msg_byte_valid,
  output logic [15:0] byte_cnt
);

  localparam logic [5:0]         EMBED   = EMBED_IDX[5:0];
  localparam logic signed [20:0] Q_MULT  = 21'(Q_RECIP);

  // Index counter and stage 1
  logic [5:0]  idx_q, idx_d, idx_eff;
  logic [11:0] s1_coef_q, s1_coef_d;
  logic        s1_v_q, s1_v_d;

  // Stage 2
  logic signed [20:0] p;
  logic [20:0]        m;
  logic [10:0]        m_frac_unused;
  logic [8:0]         qm, q;
  logic [7:0]         q_hi_unused;
  logic               s2_lsb_q, s2_lsb_d;
  logic               s2_v_q, s2_v_d;

  // Output stage
  logic [18:0] lfsr_1_q, lfsr_1_d;
  logic [21:0] lfsr_2_q, lfsr_2_d;
  logic [22:0] lfsr_3_q, lfsr_3_d;
  logic [6:0]  shift_q, shift_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        msg_bit_q, msg_bit_d;
  logic        msg_bit_valid_q, msg_bit_valid_d;
  logic [7:0]  msg_byte_q, msg_byte_d;
  logic        msg_byte_valid_q, msg_byte_valid_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        ks, out_bit;

  // blk_sync forces the current coefficient to index 0, so a sync landing on
  // what would have been the embed slot does not extract.
  always_comb begin
    idx_eff   = blk_sync ? 6'd0 : idx_q;
    idx_d     = idx_q;
    s1_v_d    = 1'b0;
    s1_coef_d = s1_coef_q;
    if (coef_valid) begin
      idx_d = idx_eff + 6'd1;
      if (idx_eff == EMBED) begin
        s1_v_d    = 1'b1;
        s1_coef_d = coef_in;
      end
    end
  end

  // Quantize by 1/18: round half up on the magnitude, then restore the sign.
  // |p| <= 2048*228 so 21 signed bits never overflow.
  always_comb begin
    p             = $signed({{9{s1_coef_q[11]}}, s1_coef_q}) * Q_MULT;
    m             = p[20] ? 21'(-p) : 21'(p);
    m_frac_unused = m[10:0];
    qm            = m[20:12] + {8'd0, m[11]};
    q             = p[20] ? 9'(-qm) : qm;
    q_hi_unused   = q[8:1];
    s2_lsb_d      = q[0];
    s2_v_d        = s1_v_q;
  end

  // Keystream sampled before the LFSRs step; they only advance on extracted bits.
  always_comb begin
    ks               = lfsr_1_q[18] ^ lfsr_2_q[21] ^ lfsr_3_q[22];
    out_bit          = s2_lsb_q ^ ks;
    lfsr_1_d         = lfsr_1_q;
    lfsr_2_d         = lfsr_2_q;
    lfsr_3_d         = lfsr_3_q;
    shift_d          = shift_q;
    ptr_d            = ptr_q;
    msg_bit_d        = msg_bit_q;
    msg_bit_valid_d  = 1'b0;
    msg_byte_d       = msg_byte_q;
    msg_byte_valid_d = 1'b0;
    byte_cnt_d       = byte_cnt_q;
    if (s2_v_q) begin
      msg_bit_d       = out_bit;
      msg_bit_valid_d = 1'b1;
      lfsr_1_d = {lfsr_1_q[17:0], lfsr_1_q[18] ^ lfsr_1_q[17] ^ lfsr_1_q[16] ^ lfsr_1_q[13]};
      lfsr_2_d = {lfsr_2_q[20:0], lfsr_2_q[21] ^ lfsr_2_q[20]};
      lfsr_3_d = {lfsr_3_q[21:0], lfsr_3_q[22] ^ lfsr_3_q[21] ^ lfsr_3_q[20] ^ lfsr_3_q[7]};
      if (ptr_q == 3'd7) begin
        // 8th bit goes straight into the byte; no need to park it in the shifter.
        msg_byte_d       = {out_bit, shift_q};
        msg_byte_valid_d = 1'b1;
        byte_cnt_d       = byte_cnt_q + 16'd1;
        ptr_d            = 3'd0;
      end else begin
        shift_d[ptr_q] = out_bit;
        ptr_d          = ptr_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q            <= 6'd0;
      s1_coef_q        <= 12'd0;
      s1_v_q           <= 1'b0;
      s2_lsb_q         <= 1'b0;
      s2_v_q           <= 1'b0;
      lfsr_1_q         <= SEED_1;
      lfsr_2_q         <= SEED_2;
      lfsr_3_q         <= SEED_3;
      shift_q          <= 7'd0;
      ptr_q            <= 3'd0;
      msg_bit_q        <= 1'b0;
      msg_bit_valid_q  <= 1'b0;
      msg_byte_q       <= 8'd0;
      msg_byte_valid_q <= 1'b0;
      byte_cnt_q       <= 16'd0;
    end else begin
      idx_q            <= idx_d;
      s1_coef_q        <= s1_coef_d;
      s1_v_q           <= s1_v_d;
      s2_lsb_q         <= s2_lsb_d;
      s2_v_q           <= s2_v_d;
      lfsr_1_q         <= lfsr_1_d;
      lfsr_2_q         <= lfsr_2_d;
      lfsr_3_q         <= lfsr_3_d;
      shift_q          <= shift_d;
      ptr_q            <= ptr_d;
      msg_bit_q        <= msg_bit_d;
      msg_bit_valid_q  <= msg_bit_valid_d;
      msg_byte_q       <= msg_byte_d;
      msg_byte_valid_q <= msg_byte_valid_d;
      byte_cnt_q       <= byte_cnt_d;
    end
  end

  assign msg_bit        = msg_bit_q;
  assign msg_bit_valid  = msg_bit_valid_q;
  assign msg_byte       = msg_byte_q;
  assign msg_byte_valid = msg_byte_valid_q;
  assign byte_cnt       = byte_cnt_q;

endmodule

// File: tb/tb_stego_decode.sv
// Bench for stego_decode: randomized and directed coefficient streams, reference model
// computing expected bits/bytes arithmetically, scoreboard queue popped by a negedge monitor.
module tb_stego_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] coef_in;
  logic        coef_valid;
  logic        blk_sync;
  logic        msg_bit;
  logic        msg_bit_valid;
  logic [7:0]  msg_byte;
  logic        msg_byte_valid;
  logic [15:0] byte_cnt;

  stego_decode dut (
    .clk            (clk),
    .rst            (rst),
    .coef_in        (coef_in),
    .coef_valid     (coef_valid),
    .blk_sync       (blk_sync),
    .msg_bit        (msg_bit),
    .msg_bit_valid  (msg_bit_valid),
    .msg_byte       (msg_byte),
    .msg_byte_valid (msg_byte_valid),
    .byte_cnt       (byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        b;
    logic        bv;
    logic [7:0]  by;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  localparam logic [31:0] TAPS_1 = (32'd1 << 18) | (32'd1 << 17) | (32'd1 << 16) | (32'd1 << 13);
  localparam logic [31:0] TAPS_2 = (32'd1 << 21) | (32'd1 << 20);
  localparam logic [31:0] TAPS_3 = (32'd1 << 22) | (32'd1 << 21) | (32'd1 << 20) | (32'd1 << 7);
  logic [31:0] l1, l2, l3;
  int          m_idx;
  int          m_ptr;
  logic [7:0]  m_shift;
  logic [15:0] m_cnt;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int w, input logic [31:0] taps);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return ((s << 1) | {31'd0, ^(s & taps)}) & mask;
  endfunction

  function automatic logic ks_now();
    return l1[18] ^ l2[21] ^ l3[22];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    l1 = 32'd1876; l2 = 32'd20007; l3 = 32'd14376;
    m_idx = 0; m_ptr = 0; m_shift = 8'd0; m_cnt = 16'd0;
    sb.delete();
  endtask

  // Feed one valid coefficient into the model: q = round(|c|/18 in 4096ths), bit = q LSB ^ keystream.
  task automatic model_coef(input int c, input bit sync);
    int   eff, mag, qm;
    exp_t e;
    eff = sync ? 0 : m_idx;
    if (eff == 43) begin
      mag   = (c < 0) ? -c : c;
      qm    = (mag * 228 + 2048) / 4096;
      e.b   = qm[0] ^ ks_now();
      l1 = lfsr_step(l1, 19, TAPS_1);
      l2 = lfsr_step(l2, 22, TAPS_2);
      l3 = lfsr_step(l3, 23, TAPS_3);
      m_shift[m_ptr] = e.b;
      e.bv  = (m_ptr == 7);
      if (e.bv) m_cnt = m_cnt + 16'd1;
      e.by  = m_shift;
      e.cnt = m_cnt;
      e.cyc = cyc + 3;
      m_ptr = (m_ptr + 1) % 8;
      sb.push_back(e);
    end
    m_idx = (eff + 1) % 64;
  endtask

  task automatic drive(input int c, input bit v, input bit sync);
    @(posedge clk);
    #1;
    coef_in    = 12'(c);
    coef_valid = v;
    blk_sync   = v & sync;
    if (v) model_coef(c, sync);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    coef_valid = 1'b0;
    blk_sync   = 1'b0;
    coef_in    = 12'd0;
    model_reset();
    #2;
    chk("rst_bit_valid",  {31'd0, msg_bit_valid},  32'd0);
    chk("rst_byte_valid", {31'd0, msg_byte_valid}, 32'd0);
    chk("rst_bit",        {31'd0, msg_bit},        32'd0);
    chk("rst_byte",       {24'd0, msg_byte},       32'd0);
    chk("rst_byte_cnt",   {16'd0, byte_cnt},       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() > 0; i++) drive(0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0);
    chk("drain_queue_empty", sb.size(), 32'd0);
  endtask

  task automatic send_block(input int c43, input bit sync_first);
    for (int i = 0; i < 64; i++) drive((i == 43) ? c43 : 0, 1'b1, sync_first && (i == 0));
  endtask

  // Encoder model: coefficient = 18*(bit ^ ks) at the embed slot.
  task automatic send_enc_byte(input logic [7:0] by);
    for (int k = 0; k < 8; k++) send_block(18 * (by[k] ^ ks_now()), 1'b1);
  endtask

  // Monitor: pop and compare on every strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (msg_bit_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: msg_bit_valid=1 with no expected bit (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bit_latency_cycle", cyc, e.cyc);
          chk("msg_bit", {31'd0, msg_bit}, {31'd0, e.b});
          chk("msg_byte_valid", {31'd0, msg_byte_valid}, {31'd0, e.bv});
          if (e.bv) begin
            chk("msg_byte", {24'd0, msg_byte}, {24'd0, e.by});
            chk("byte_cnt", {16'd0, byte_cnt}, {16'd0, e.cnt});
          end
        end
      end else if (msg_byte_valid) begin
        checks++;
        errors++;
        $display("FAIL byte_without_bit: msg_byte_valid=1 while msg_bit_valid=0 (t=%0t)", $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    rst = 1'b1; coef_in = 12'd0; coef_valid = 1'b0; blk_sync = 1'b0;
    model_reset();
    do_reset();

    // 64 zeros: one bit, value 0 (keystream starts at 0)
    send_block(0, 1'b0);
    drain();

    // Sign and rounding cases on the embed slot
    send_block(54, 1'b0);
    send_block(-54, 1'b0);
    send_block(27, 1'b0);
    send_block(36, 1'b0);
    send_block(-27, 1'b1);
    send_block(2047, 1'b0);
    send_block(-2048, 1'b0);
    drain();

    // blk_sync landing on the would-be embed coefficient: restarts at index 0
    for (int i = 0; i < 43; i++) drive(0, 1'b1, 1'b0);
    drive(54, 1'b1, 1'b1);
    send_block(54, 1'b0);
    drain();

    // Byte 0xA5 through the encoder model from a clean reset
    do_reset();
    send_enc_byte(8'hA5);
    drain();
    chk("a5_byte", {24'd0, msg_byte}, 32'h0000_00A5);
    chk("a5_byte_cnt", {16'd0, byte_cnt}, 32'd1);

    // Random gaps, random coefficients, occasional mid-block sync
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 4095) - 2048,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 199) == 0);
    end
    drain();

    // 5 bits, then reset with a 6th bit in flight, then a fresh byte
    do_reset();
    for (int k = 0; k < 5; k++) send_block($urandom_range(0, 4095) - 2048, 1'b1);
    drain();
    for (int i = 0; i < 44; i++) drive((i == 43) ? 54 : 0, 1'b1, i == 0);
    do_reset();
    rb = 8'($urandom_range(0, 255));
    send_enc_byte(rb);
    drain();
    chk("post_rst_byte", {24'd0, msg_byte}, {24'd0, rb});
    chk("post_rst_byte_cnt", {16'd0, byte_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stego_decode.md
Name: stego_decode

Overview:
Receive-side counterpart of the stego encoder. It consumes the 12-bit 2-D DCT coefficient stream of stego video, one coefficient per valid strobe, 64 per 8x8 block, from an MDCT instance in the decoder top. For each block it:
- takes the coefficient at the embed index;
- quantizes it by 1/18;
- recovers the hidden bit as the LSB, XORed with the shared three-LFSR keystream;
- packs the recovered bits LSB-first into message bytes.

Parameters:
EMBED_IDX, 43, in-block coefficient index carrying the hidden bit (0..63)
Q_RECIP, 228, 1/18 scaled by 4096 (unsigned, 9-bit signed container)
SEED_1, 19'd1876, reset value of lfsr_1
SEED_2, 22'd20007, reset value of lfsr_2
SEED_3, 23'd14376, reset value of lfsr_3

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
coef_in  in  12  signed DCT coefficient (-2048..2047)
coef_valid  in  1  coef_in valid this cycle; gaps of any length allowed
blk_sync  in  1  with coef_valid: this coefficient is index 0 of a block
msg_bit  out  1  recovered (descrambled) message bit
msg_bit_valid  out  1  one-cycle strobe qualifying msg_bit
msg_byte  out  8  packed message byte, bit 0 = first recovered bit
msg_byte_valid  out  1  one-cycle strobe qualifying msg_byte
byte_cnt  out  16  count of bytes emitted since reset, wraps at 65535->0

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - all outputs are 0, idx = 0, bit pointer = 0, pipeline valid tags = 0;
  - lfsr_1/2/3 load SEED_1/2/3.
  - Reset mid-byte discards the partial byte. Reset mid-pipeline drops an in-flight bit (no strobe).
- Index counter idx (6 bits):
  - on coef_valid: if blk_sync, the coefficient is treated as index 0 and idx becomes 1; otherwise the coefficient takes index idx and idx increments;
  - wraps 63->0;
  - unchanged when coef_valid = 0.
- Pipeline: fixed latency, advances every clock, each stage carries a valid tag.
  - S1, at edge T: coef_valid and (index == EMBED_IDX) → s1_coef <= coef_in, s1_v <= 1; otherwise s1_v <= 0.
  - S2, at edge T+1: compute
    - p = s1_coef * Q_RECIP (21-bit signed);
    - m = |p|;
    - qm = m[20:12] + m[11] (round half up on magnitude);
    - q = sign(p) ? -qm : qm (9-bit signed).
    - Register s2_lsb <= q[0], s2_v <= s1_v.
    - Max |p| = 466944, so there is no overflow.
- Output stage, at edge T+2, when s2_v:
  - msg_bit <= s2_lsb ^ ks, with ks = lfsr_1[18] ^ lfsr_2[21] ^ lfsr_3[22] sampled before the step;
  - msg_bit_valid <= 1;
  - all three LFSRs step once;
  - msg_byte_shift[ptr] <= bit, ptr++.
  - msg_bit holds its value between strobes; msg_bit_valid is high for one cycle only.
- LFSR steps (shift left, feedback into bit 0):
  - lfsr_1 fb = b18^b17^b16^b13;
  - lfsr_2 fb = b21^b20;
  - lfsr_3 fb = b22^b21^b20^b7.
  - LFSRs step only on extracted bits, never on other coefficients.
- Byte assembly:
  - when ptr == 7 and a bit is emitted, msg_byte <= {bit, shift[6:0]}, msg_byte_valid <= 1 in the same cycle as the 8th msg_bit_valid, byte_cnt++, and ptr wraps to 0;
  - msg_byte holds until the next completed byte.
- Simultaneous events:
  - blk_sync on the embed-index coefficient: its index is 0, so no extraction unless EMBED_IDX = 0;
  - back-to-back blocks sustain one bit every 64 valid coefficients with no stall.
- No backpressure. The consumer must take the strobes.

Test Plan:
- Reset only, then 64 zero coefficients → msg_bit_valid once, 2 cycles after the index-43 sample; msg_bit = 0 (ks = 0 for all seeds' MSBs); LFSRs stepped once.
- First block after reset, coefficient 54 at idx 43, others 0 → q = 3, msg_bit = 1; coefficient -54 → q = -3, msg_bit = 1.
- Rounding: coefficient 27 (p = 6156, m[11] = 1) → q = 2, bit 0; coefficient 36 (p = 8208) → q = 2, bit 0.
- 8 consecutive blocks encoding byte 0xA5 through the stego encoder model (coefficient = 18*(bit^ks) at idx 43) → msg_byte = 0xA5, msg_byte_valid coincident with the 8th msg_bit_valid, byte_cnt = 1.
- Random coef_valid gaps plus blk_sync asserted mid-block → index restarts, extraction at the new index 43; bit stream matches the golden model.
- Assert rst after 5 bits, then 8 blocks → first byte contains only post-reset bits, and the keystream restarts from the seeds.
